// File: rtl/hamming_uart_rx_if.sv
// Signal bundle between the Hamming UART receiver and whatever consumes its
// decoded bytes. The receiver takes the master view; the consumer takes the
// slave view and may also drive the serial line in a bench setting.
`timescale 1ns/1ps
interface hamming_uart_rx_if;
  logic       serial_in;
  logic [7:0] parallel_out;
  logic       valid;
  logic       corrected;
  logic       uncorrectable;
  logic       frame_err;
  logic       busy;

  modport master (
    input  serial_in,
    output parallel_out,
    output valid,
    output corrected,
    output uncorrectable,
    output frame_err,
    output busy
  );

  modport slave (
    output serial_in,
    input  parallel_out,
    input  valid,
    input  corrected,
    input  uncorrectable,
    input  frame_err,
    input  busy
  );
endinterface

// File: rtl/hamming_uart_rx.sv
// UART receiver that deframes one 12-bit Hamming(12,8) codeword per frame
// (start, c[0]..c[11] LSB first, stop), corrects any single-bit error and
// presents the recovered byte with a one-cycle valid strobe.
`timescale 1ns/1ps
module hamming_uart_rx #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int BIT_RATE = 115_200
) (
  input  logic              clk,
  input  logic              reset,
  hamming_uart_rx_if.master rx
);

  localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
  localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
  localparam int CNT_W          = $clog2(CYCLES_PER_BIT + 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    DECODE
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             prev_q, prev_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_idx_q, bit_idx_d;
  logic [11:0]      shreg_q, shreg_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             corrected_q, corrected_d;
  logic             uncorrectable_q, uncorrectable_d;
  logic             frame_err_q, frame_err_d;

  logic [3:0]       syndrome;
  logic             syn_correctable;
  logic             syn_uncorrectable;
  logic [11:0]      flip_mask;
  logic [11:0]      fixed_word;
  logic [7:0]       decoded_byte;

  // Two-flop synchronizer plus a one-cycle-delayed copy for falling-edge detection.
  always_comb begin
    sync1_d = rx.serial_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // Syndrome of the captured codeword; each mask selects the positions one parity bit covers.
  always_comb begin
    syndrome[0]       = ^(shreg_q & 12'h555);
    syndrome[1]       = ^(shreg_q & 12'h666);
    syndrome[2]       = ^(shreg_q & 12'h878);
    syndrome[3]       = ^(shreg_q & 12'hF80);
    syn_correctable   = (syndrome != 4'd0) && (syndrome <= 4'd12);
    syn_uncorrectable = (syndrome >= 4'd13);
    flip_mask         = '0;
    if (syn_correctable) begin
      flip_mask = 12'd1 << (syndrome - 4'd1);
    end
    fixed_word   = shreg_q ^ flip_mask;
    decoded_byte = {fixed_word[11:8], fixed_word[6:4], fixed_word[2]};
  end

  // Receive FSM; the decoded result is registered as STOP accepts the stop bit,
  // so the output pulses line up with the single DECODE cycle.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q + CNT_W'(1);
    bit_idx_d       = bit_idx_q;
    shreg_d         = shreg_q;
    data_d          = data_q;
    valid_d         = 1'b0;
    corrected_d     = 1'b0;
    uncorrectable_d = 1'b0;
    frame_err_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (prev_q && !sync2_q) begin
          bit_idx_d = '0;
          state_d   = START;
        end
      end

      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = sync2_q ? IDLE : DATA;
        end
      end

      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          shreg_d   = {sync2_q, shreg_q[11:1]};
          bit_idx_d = bit_idx_q + 4'd1;
          if (bit_idx_q == 4'd11) begin
            state_d = STOP;
          end
        end
      end

      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (sync2_q) begin
            data_d          = decoded_byte;
            valid_d         = 1'b1;
            corrected_d     = syn_correctable;
            uncorrectable_d = syn_uncorrectable;
            state_d         = DECODE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = IDLE;
          end
        end
      end

      DECODE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset; the line idles high.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      sync1_q         <= 1'b1;
      sync2_q         <= 1'b1;
      prev_q          <= 1'b1;
      cnt_q           <= '0;
      bit_idx_q       <= '0;
      shreg_q         <= '0;
      data_q          <= 8'h00;
      valid_q         <= 1'b0;
      corrected_q     <= 1'b0;
      uncorrectable_q <= 1'b0;
      frame_err_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      sync1_q         <= sync1_d;
      sync2_q         <= sync2_d;
      prev_q          <= prev_d;
      cnt_q           <= cnt_d;
      bit_idx_q       <= bit_idx_d;
      shreg_q         <= shreg_d;
      data_q          <= data_d;
      valid_q         <= valid_d;
      corrected_q     <= corrected_d;
      uncorrectable_q <= uncorrectable_d;
      frame_err_q     <= frame_err_d;
    end
  end

  assign rx.parallel_out  = data_q;
  assign rx.valid         = valid_q;
  assign rx.corrected     = corrected_q;
  assign rx.uncorrectable = uncorrectable_q;
  assign rx.frame_err     = frame_err_q;
  assign rx.busy          = (state_q != IDLE);

endmodule

// File: tb/tb_hamming_uart_rx.sv
// Directed bench for hamming_uart_rx. One instance runs at the default
// 100 MHz / 115200 rate for the exact-latency and glitch cases; a second
// instance at 16 clocks per bit carries the vector table, back-to-back
// frames and the mid-frame reset, keeping the run short.
`timescale 1ns/1ps
module tb_hamming_uart_rx;

  localparam int FULL_CPB    = 100_000_000 / 115_200;
  localparam int FAST_CLK_HZ = 16 * 115_200;
  localparam int FAST_CPB    = FAST_CLK_HZ / 115_200;
  localparam int FULL_LAT    = 2 + FULL_CPB / 2 + FULL_CPB * 13 + 1;
  localparam int FAST_LAT    = 2 + FAST_CPB / 2 + FAST_CPB * 13 + 1;
  localparam int NVEC        = 12;

  typedef struct {
    string       name;
    logic [11:0] cw;
    logic        stop_bit;
    int          exp_valid;
    logic [7:0]  exp_byte;
    int          exp_corr;
    int          exp_unc;
    int          exp_fe;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  hamming_uart_rx_if full_if ();
  hamming_uart_rx_if fast_if ();

  hamming_uart_rx u_full (
    .clk   (clk),
    .reset (reset),
    .rx    (full_if)
  );

  hamming_uart_rx #(
    .CLK_HZ   (FAST_CLK_HZ),
    .BIT_RATE (115_200)
  ) u_fast (
    .clk   (clk),
    .reset (reset),
    .rx    (fast_if)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event counters observed on the falling edge, away from the active edge.
  int f_valid_n = 0, f_corr_n = 0, f_unc_n = 0, f_fe_n = 0, f_excl_n = 0;
  int f_last_valid_cyc = 0, f_start_cyc = 0;
  logic [7:0] f_bytes[$];
  int u_valid_n = 0, u_corr_n = 0, u_unc_n = 0, u_fe_n = 0, u_excl_n = 0;
  int u_busy_n = 0, u_last_valid_cyc = 0, u_start_cyc = 0;

  always @(negedge clk) begin
    if (fast_if.valid) begin
      f_valid_n++;
      f_last_valid_cyc = cyc;
      f_bytes.push_back(fast_if.parallel_out);
    end
    if (fast_if.corrected)     f_corr_n++;
    if (fast_if.uncorrectable) f_unc_n++;
    if (fast_if.frame_err)     f_fe_n++;
    if ((fast_if.valid && fast_if.frame_err) ||
        (fast_if.corrected && fast_if.uncorrectable) ||
        ((fast_if.corrected || fast_if.uncorrectable) && !fast_if.valid))
      f_excl_n++;

    if (full_if.valid) begin
      u_valid_n++;
      u_last_valid_cyc = cyc;
    end
    if (full_if.corrected)     u_corr_n++;
    if (full_if.uncorrectable) u_unc_n++;
    if (full_if.frame_err)     u_fe_n++;
    if (full_if.busy)          u_busy_n++;
    if ((full_if.valid && full_if.frame_err) ||
        (full_if.corrected && full_if.uncorrectable) ||
        ((full_if.corrected || full_if.uncorrectable) && !full_if.valid))
      u_excl_n++;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkRange(input string name, input int actual, input int lo, input int hi);
    checks++;
    if (actual < lo || actual > hi) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
    end
  endtask

  // Sends one frame on the fast line: start, 12 codeword bits LSB first, stop.
  task automatic applyStimulus(input logic [11:0] cw, input logic stop_bit);
    fast_if.serial_in = 1'b0;
    f_start_cyc = cyc;
    idle(FAST_CPB);
    for (int i = 0; i < 12; i++) begin
      fast_if.serial_in = cw[i];
      idle(FAST_CPB);
    end
    fast_if.serial_in = stop_bit;
    idle(FAST_CPB);
    fast_if.serial_in = 1'b1;
  endtask

  task automatic sendFullFrame(input logic [11:0] cw);
    full_if.serial_in = 1'b0;
    u_start_cyc = cyc;
    idle(FULL_CPB);
    for (int i = 0; i < 12; i++) begin
      full_if.serial_in = cw[i];
      idle(FULL_CPB);
    end
    full_if.serial_in = 1'b1;
    idle(FULL_CPB);
  endtask

  vec_t vecs[NVEC];
  int   v0, c0, u0, e0, b0;
  logic [7:0] b2b_exp[4];

  initial begin
    vecs[0]  = '{"clean BF3",          12'hBF3, 1'b1, 1, 8'hBE, 0, 0, 0};
    vecs[1]  = '{"pos6 flip BD3",      12'hBD3, 1'b1, 1, 8'hBE, 1, 0, 0};
    vecs[2]  = '{"syndrome13 B7A",     12'hB7A, 1'b1, 1, 8'hBE, 0, 1, 0};
    vecs[3]  = '{"stop low BF3",       12'hBF3, 1'b0, 0, 8'hBE, 0, 0, 1};
    vecs[4]  = '{"clean after ferr",   12'hBF3, 1'b1, 1, 8'hBE, 0, 0, 0};
    vecs[5]  = '{"clean FF F77",       12'hF77, 1'b1, 1, 8'hFF, 0, 0, 0};
    vecs[6]  = '{"pos1 flip F76",      12'hF76, 1'b1, 1, 8'hFF, 1, 0, 0};
    vecs[7]  = '{"pos12 flip 3F3",     12'h3F3, 1'b1, 1, 8'hBE, 1, 0, 0};
    vecs[8]  = '{"clean 01 007",       12'h007, 1'b1, 1, 8'h01, 0, 0, 0};
    vecs[9]  = '{"pos2 flip 005",      12'h005, 1'b1, 1, 8'h01, 1, 0, 0};
    vecs[10] = '{"syndrome14 08A",     12'h08A, 1'b1, 1, 8'h00, 0, 1, 0};
    vecs[11] = '{"stop low 007",       12'h007, 1'b0, 0, 8'h00, 0, 0, 1};
    b2b_exp  = '{8'hBE, 8'hBE, 8'h00, 8'hBE};

    full_if.serial_in = 1'b1;
    fast_if.serial_in = 1'b1;
    reset = 1'b1;
    idle(5);

    $display("[TB] reset state");
    checkOutput("reset parallel_out", fast_if.parallel_out, 8'h00);
    checkOutput("reset valid", fast_if.valid, 0);
    checkOutput("reset busy", fast_if.busy, 0);
    checkOutput("reset frame_err", fast_if.frame_err, 0);
    checkOutput("reset corrected", full_if.corrected, 0);
    checkOutput("reset uncorrectable", full_if.uncorrectable, 0);
    reset = 1'b0;
    idle(5);

    $display("[TB] full-rate clean frame");
    sendFullFrame(12'hBF3);
    idle(4);
    checkOutput("full valid count", u_valid_n, 1);
    checkOutput("full byte", full_if.parallel_out, 8'hBE);
    checkOutput("full corrected count", u_corr_n, 0);
    checkOutput("full uncorrectable count", u_unc_n, 0);
    checkOutput("full valid latency", u_last_valid_cyc - u_start_cyc, FULL_LAT);

    $display("[TB] full-rate 200-cycle glitch");
    b0 = u_busy_n;
    v0 = u_valid_n;
    e0 = u_fe_n;
    full_if.serial_in = 1'b0;
    idle(200);
    full_if.serial_in = 1'b1;
    idle(1000);
    checkOutput("glitch valid count", u_valid_n - v0, 0);
    checkOutput("glitch frame_err count", u_fe_n - e0, 0);
    checkRange("glitch busy cycles", u_busy_n - b0, 430, 440);
    checkOutput("glitch byte held", full_if.parallel_out, 8'hBE);

    $display("[TB] fast-rate vector table");
    for (int i = 0; i < NVEC; i++) begin
      v0 = f_valid_n;
      c0 = f_corr_n;
      u0 = f_unc_n;
      e0 = f_fe_n;
      applyStimulus(vecs[i].cw, vecs[i].stop_bit);
      idle(4);
      checkOutput({vecs[i].name, " valid"}, f_valid_n - v0, vecs[i].exp_valid);
      checkOutput({vecs[i].name, " corrected"}, f_corr_n - c0, vecs[i].exp_corr);
      checkOutput({vecs[i].name, " uncorrectable"}, f_unc_n - u0, vecs[i].exp_unc);
      checkOutput({vecs[i].name, " frame_err"}, f_fe_n - e0, vecs[i].exp_fe);
      checkOutput({vecs[i].name, " byte"}, fast_if.parallel_out, vecs[i].exp_byte);
      if (vecs[i].exp_valid == 1)
        checkOutput({vecs[i].name, " latency"}, f_last_valid_cyc - f_start_cyc, FAST_LAT);
    end

    $display("[TB] back-to-back frames");
    v0 = f_valid_n;
    c0 = f_corr_n;
    b0 = f_bytes.size();
    applyStimulus(12'hBF3, 1'b1);
    applyStimulus(12'hBD3, 1'b1);
    applyStimulus(12'h000, 1'b1);
    applyStimulus(12'hBF3, 1'b1);
    idle(4);
    checkOutput("b2b valid count", f_valid_n - v0, 4);
    checkOutput("b2b corrected count", f_corr_n - c0, 1);
    for (int i = 0; i < 4; i++) begin
      if (f_bytes.size() > b0 + i)
        checkOutput($sformatf("b2b byte %0d", i), f_bytes[b0 + i], b2b_exp[i]);
      else
        checkOutput($sformatf("b2b byte %0d present", i), 0, 1);
    end

    $display("[TB] reset mid-DATA");
    v0 = f_valid_n;
    e0 = f_fe_n;
    fork
      applyStimulus(12'hFFF, 1'b1);
      begin
        idle(60);
        checkOutput("busy before reset", fast_if.busy, 1);
        reset = 1'b1;
        idle(1);
        checkOutput("after reset busy", fast_if.busy, 0);
        checkOutput("after reset parallel_out", fast_if.parallel_out, 8'h00);
        checkOutput("after reset valid", fast_if.valid, 0);
        checkOutput("after reset frame_err", fast_if.frame_err, 0);
        reset = 1'b0;
      end
    join
    idle(20);
    checkOutput("dropped frame valid", f_valid_n - v0, 0);
    checkOutput("dropped frame frame_err", f_fe_n - e0, 0);
    applyStimulus(12'hBF3, 1'b1);
    idle(4);
    checkOutput("post-reset valid", f_valid_n - v0, 1);
    checkOutput("post-reset byte", fast_if.parallel_out, 8'hBE);

    checkOutput("fast exclusion violations", f_excl_n, 0);
    checkOutput("full exclusion violations", u_excl_n, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
